// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers.
// Single-precision layout, divider states, special-value tests.
package fpu_pkg;

  localparam int         BIAS    = 127;
  localparam int         EXP_W   = 8;
  localparam int         MAN_W   = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  typedef enum logic [2:0] {
    IDLE,
    INV,
    MUL,
    RND,
    DONE
  } fdiv_state_t;

  function automatic logic is_zero(float_t f);
    return f.exp == '0;
  endfunction

  function automatic logic is_inf(float_t f);
    return f.exp == EXP_MAX;
  endfunction

endpackage

// File: rtl/finv.sv
// Registered single-precision reciprocal, one cycle latency.
// Exact for power-of-two inputs, nearest rounding otherwise.
module finv
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] x,
  output logic [31:0] y
);

  float_t            f;
  logic [23:0]       m;
  logic [25:0]       q;
  logic [22:0]       rm;
  logic signed [9:0] re;
  logic [31:0]       r;

  assign f  = x;
  assign m  = {1'b1, f.man};
  assign q  = 26'((49'h1 << 48) / {25'h0, m});
  assign rm = 23'((q + 26'd1) >> 1);
  assign re = (f.man == '0)
            ? 10'sd254 - signed'({2'b0, f.exp})
            : 10'sd253 - signed'({2'b0, f.exp});

  // zero -> inf, inf or tiny result -> zero, else scaled reciprocal
  always_comb begin
    r = '0;
    unique case (1'b1)
      is_zero(f):
        r = {f.sign, EXP_MAX, 23'h0};
      is_inf(f) || re <= 10'sd0:
        r = {f.sign, 31'h0};
      default:
        r = {f.sign, re[7:0], (f.man == '0) ? 23'h0 : rm};
    endcase
  end

  // result register
  always_ff @(posedge clk) begin
    y <= r;
  end

endmodule

// File: rtl/fmul_core.sv
// Mantissa product plus normalise/round/range stage.
// Product and rounding are split so callers can register between them.
module fmul_core
  import fpu_pkg::*;
(
  input  logic [23:0]       ma,
  input  logic [23:0]       mb,
  output logic [47:0]       p,
  input  logic [47:0]       pq,
  input  logic signed [9:0] e,
  input  logic              s,
  output logic [31:0]       y
);

  logic [22:0]       man;
  logic              g;
  logic              st;
  logic signed [9:0] en;
  logic [23:0]       mr;
  logic signed [9:0] ef;

  assign p = ma * mb;

  // normalise: product of two 1.x values is in [1,4)
  always_comb begin
    if (pq[47]) begin
      man = pq[46:24];
      g   = pq[23];
      st  = |pq[22:0];
      en  = e + 10'sd1;
    end else begin
      man = pq[45:23];
      g   = pq[22];
      st  = |pq[21:0];
      en  = e;
    end
  end

  assign mr = {1'b0, man} + 24'(g & (st | man[0]));
  assign ef = mr[23] ? en + 10'sd1 : en;

  // range check: saturate to inf, flush to zero
  always_comb begin
    if (ef >= 10'sd255) begin
      y = {s, EXP_MAX, 23'h0};
    end else if (ef <= 10'sd0) begin
      y = {s, 31'h0};
    end else begin
      y = {s, ef[7:0], mr[22:0]};
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential divider: y = x1 * finv(x2).
// One operation in flight, valid/ready on both sides.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int FINV_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  fdiv_state_t       state, nxt;
  float_t            a_q, b_q, r_q;
  logic              sp_q, spinf_q;
  logic [7:0]        cnt;
  logic              last;
  logic              acc;
  logic [47:0]       p_d, p_q;
  logic signed [9:0] e_q;
  logic              s_q;
  logic [31:0]       finv_x, finv_y, core_y;
  float_t            f1, f2;

  assign f1     = x1;
  assign f2     = x2;
  assign acc    = in_valid && in_ready;
  assign last   = cnt == 8'(FINV_LAT - 1);
  assign finv_x = (state == IDLE) ? x2 : b_q;

  finv u_finv (
    .clk (clk),
    .x   (finv_x),
    .y   (finv_y)
  );

  fmul_core u_core (
    .ma (24'({1'b1, a_q.man})),
    .mb (24'({1'b1, r_q.man})),
    .p  (p_d),
    .pq (p_q),
    .e  (e_q),
    .s  (s_q),
    .y  (core_y)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = INV;
      INV:  if (last) nxt = MUL;
      MUL:  nxt = RND;
      RND:  nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end

  // datapath: operand latch, reciprocal capture, product, result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sp_q    <= 1'b0;
      spinf_q <= 1'b0;
      cnt     <= '0;
      p_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      y       <= '0;
    end else begin
      unique case (state)
        IDLE: if (acc) begin
          a_q     <= f1;
          b_q     <= f2;
          sp_q    <= is_zero(f1) | is_zero(f2)
                   | is_inf(f1) | is_inf(f2);
          spinf_q <= (is_zero(f2) & ~is_zero(f1))
                   | (is_inf(f1) & ~is_inf(f2));
          cnt     <= '0;
        end
        INV: begin
          cnt <= cnt + 8'd1;
          if (last) r_q <= finv_y;
        end
        MUL: begin
          p_q <= p_d;
          e_q <= signed'({2'b0, a_q.exp})
               + signed'({2'b0, r_q.exp})
               - 10'(BIAS);
          s_q <= a_q.sign ^ r_q.sign;
        end
        RND: begin
          if (sp_q)
            y <= spinf_q ? {s_q, EXP_MAX, 23'h0}
                         : {s_q, 31'h0};
          else
            y <= core_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq.
// Hand-computed quotients, latency, backpressure and reset.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;

  localparam int LAT = 4;

  fdiv_seq #(.FINV_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic op(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] want);
    int n;
    launch(tag, a, b);
    wait_out(n);
    chk({tag, ".lat"}, 32'(n), 32'(LAT));
    chk({tag, ".y"}, y, want);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".ovlo"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    step();
    step();
    rst = 1'b0;
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.y", y, 32'h0);

    op("3/2", 32'h40400000, 32'h40000000, 32'h3FC00000);
    op("6/3", 32'h40C00000, 32'h40400000, 32'h40000000);
    op("m1/0", 32'hBF800000, 32'h00000000, 32'hFF800000);
    op("0/2", 32'h00000000, 32'h40000000, 32'h00000000);
    op("inf/m2", 32'h7F800000, 32'hC0000000, 32'hFF800000);
    op("1/inf", 32'h3F800000, 32'h7F800000, 32'h00000000);
    op("0/0", 32'h80000000, 32'h00000000, 32'h80000000);
    op("ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000);
    op("unf", 32'h00800000, 32'h40000000, 32'h00000000);

    // backpressure: result held, new request ignored in DONE
    launch("bp", 32'h40400000, 32'h40000000);
    wait_out(n);
    chk("bp.lat", 32'(n), 32'(LAT));
    chk("bp.y", y, 32'h3FC00000);
    x1 = 32'h3F800000;
    x2 = 32'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.hold.y", y, 32'h3FC00000);
      chk("bp.hold.ov", 32'(out_valid), 32'd1);
      chk("bp.hold.rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.hs.ov", 32'(out_valid), 32'd0);
    chk("bp.hs.rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp2.lat", 32'(n), 32'(LAT));
    chk("bp2.y", y, 32'h3F000000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset in the middle of an operation
    launch("rmid", 32'h40A00000, 32'h40000000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid.ov", 32'(out_valid), 32'd0);
    chk("rmid.y", y, 32'h0);
    chk("rmid.rdy", 32'(in_ready), 32'd1);
    op("1/2", 32'h3F800000, 32'h40000000, 32'h3F000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
